// File: rtl/issue_queue_mw.sv
// Multi-lane FIFO issue buffer between decode and issue.
// Sparse input lanes are compacted on write. Outputs are first-word-fall-through from state.
// Full and empty are resolved from the occupancy count, never from pointer equality.
module issue_queue_mw #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ENTRY_W     = 256,
    parameter int unsigned IN_W        = 2,
    parameter int unsigned OUT_W       = 2,
    parameter int unsigned AFULL_SLACK = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         stall,
    input  logic [IN_W-1:0]              in_valid,
    input  logic [IN_W*ENTRY_W-1:0]      in_data,
    input  logic [$clog2(OUT_W+1)-1:0]   deq_num,
    output logic [OUT_W-1:0]             out_valid,
    output logic [OUT_W*ENTRY_W-1:0]     out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         overflow_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0]   eff_deq;
    logic [CW-1:0]   n_in;
    logic [CW-1:0]   space;
    logic [CW-1:0]   accepted;
    logic [CW-1:0]   rank [IN_W];
    logic [IN_W-1:0] wr_en;

    // Effective dequeue: nothing while stalled, else request clamped to occupancy and lane count
    always_comb begin
        eff_deq = '0;
        if (!stall) begin
            eff_deq = CW'(deq_num);
            if (eff_deq > count_q) eff_deq = count_q;
            if (eff_deq > CW'(OUT_W)) eff_deq = CW'(OUT_W);
        end
    end

    // Compaction: each valid lane's rank is the number of valid lanes below it
    always_comb begin
        n_in = '0;
        for (int i = 0; i < IN_W; i++) begin
            rank[i] = n_in;
            if (in_valid[i]) n_in = n_in + CW'(1);
        end
    end

    // Acceptance: same-cycle dequeue frees space; the highest-ranked lanes are the ones dropped
    always_comb begin
        space    = CW'(DEPTH) - count_q + eff_deq;
        accepted = (n_in < space) ? n_in : space;
        for (int i = 0; i < IN_W; i++) begin
            wr_en[i] = in_valid[i] && (rank[i] < accepted) && !flush;
        end
    end

    // Next-state pointers, occupancy and flags; flush overrides stall and enqueue
    always_comb begin
        head_d  = head_q + PW'(accepted);
        tail_d  = tail_q + PW'(eff_deq);
        count_d = count_q + accepted - eff_deq;
        afull_d = (32'(DEPTH) - 32'(count_d)) < 32'(AFULL_SLACK);
        ovf_d   = ovf_q | (n_in > accepted);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            afull_d = 1'b0;
            ovf_d   = ovf_q;
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage write; contents are never exposed while invalid, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_W; i++) begin
            if (wr_en[i]) begin
                mem[head_q + PW'(rank[i])] <= in_data[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Fall-through head window: lane k shows the k-th oldest entry
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < OUT_W; k++) begin
            out_valid[k]                  = count_q > CW'(k);
            out_data[k*ENTRY_W +: ENTRY_W] = mem[tail_q + PW'(k)];
        end
    end

    assign count        = count_q;
    assign almost_full  = afull_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_issue_queue_mw.sv
// Self-checking bench for issue_queue_mw with a queue-based reference model.
module tb_issue_queue_mw;

    localparam int DEPTH = 16;
    localparam int EW    = 256;

    logic           clk = 1'b0;
    logic           rstn;
    logic           flush;
    logic           stall;
    logic [1:0]     in_valid;
    logic [2*EW-1:0] in_data;
    logic [1:0]     deq_num;
    logic [1:0]     out_valid;
    logic [2*EW-1:0] out_data;
    logic [4:0]     count;
    logic           almost_full;
    logic           overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] q [$];
    bit            m_af;
    bit            m_ovf;

    issue_queue_mw #(
        .DEPTH(16), .ENTRY_W(256), .IN_W(2), .OUT_W(2), .AFULL_SLACK(4)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_data(in_data), .deq_num(deq_num),
        .out_valid(out_valid), .out_data(out_data), .count(count),
        .almost_full(almost_full), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] rnd();
        logic [EW-1:0] v;
        for (int i = 0; i < EW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic compare_state(input string tag);
        logic [1:0] ev;
        ev = {q.size() > 1, q.size() > 0};
        check({tag, "_count"}, EW'(count), EW'(q.size()));
        check({tag, "_valid"}, EW'(out_valid), EW'(ev));
        check({tag, "_afull"}, EW'(almost_full), EW'(m_af));
        check({tag, "_ovf"}, EW'(overflow_err), EW'(m_ovf));
        for (int k = 0; k < 2; k++) begin
            if (k < q.size()) check($sformatf("%s_data%0d", tag, k), out_data[k*EW +: EW], q[k]);
        end
    endtask

    // Drive one cycle, advance the model from the spec's rules, then compare after the edge
    task automatic step(input bit fl, input bit st, input logic [1:0] iv,
                        input logic [EW-1:0] a, input logic [EW-1:0] b,
                        input logic [1:0] dn, input string tag);
        int ed;
        logic [EW-1:0] lane [2];
        flush    = fl;
        stall    = st;
        in_valid = iv;
        in_data  = {b, a};
        deq_num  = dn;
        lane[0]  = a;
        lane[1]  = b;
        if (fl) begin
            q.delete();
            m_af = 1'b0;
        end else begin
            ed = st ? 0 : int'(dn);
            if (ed > q.size()) ed = q.size();
            if (ed > 2) ed = 2;
            repeat (ed) void'(q.pop_front());
            for (int i = 0; i < 2; i++) begin
                if (iv[i]) begin
                    if (q.size() < DEPTH) q.push_back(lane[i]);
                    else m_ovf = 1'b1;
                end
            end
            m_af = (DEPTH - q.size()) < 4;
        end
        @(posedge clk);
        #1;
        compare_state(tag);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic pulse_reset(input string tag);
        rstn = 1'b0;
        q.delete();
        m_af  = 1'b0;
        m_ovf = 1'b0;
        #2;
        compare_state(tag);
        #2;
        rstn = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b00, '0, '0, 2'd0, "idle");
    endtask

    initial begin
        logic [EW-1:0] a, b, c;
        rstn = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = '0; in_data = '0; deq_num = '0;
        m_af = 1'b0; m_ovf = 1'b0;
        #3;
        compare_state("reset");
        repeat (2) @(posedge clk);
        #4 rstn = 1'b1;
        @(posedge clk); #1;

        // 1: two lanes into an empty queue
        a = rnd(); b = rnd();
        step(1'b0, 1'b0, 2'b11, a, b, 2'd0, "tp1");
        check("tp1_outdata", out_data[2*EW-1:0] >> EW, b);
        check("tp1_lane0", out_data[EW-1:0], a);

        // 2: sparse lane 1 only lands in output lane 0
        pulse_reset("rst2");
        c = rnd();
        step(1'b0, 1'b0, 2'b10, rnd(), c, 2'd0, "tp2");
        check("tp2_lane0", out_data[EW-1:0], c);

        // 3: overflow at the full boundary
        pulse_reset("rst3");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd0, "fill");
        step(1'b0, 1'b0, 2'b01, rnd(), rnd(), 2'd0, "fill15");
        step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd0, "tp3a");
        check("tp3a_count16", EW'(count), EW'(16));
        check("tp3a_ovf_set", EW'(overflow_err), EW'(1));
        step(1'b0, 1'b0, 2'b00, '0, '0, 2'd3, "drain_clamp");
        pulse_reset("rst3b");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd0, "fill");
        step(1'b0, 1'b0, 2'b01, rnd(), rnd(), 2'd0, "fill15");
        step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd1, "tp3b");
        check("tp3b_ovf_clear", EW'(overflow_err), EW'(0));

        // 4: stall holds the head while enqueue continues
        pulse_reset("rst4");
        step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd0, "s4a");
        step(1'b0, 1'b0, 2'b01, rnd(), rnd(), 2'd0, "s4b");
        step(1'b0, 1'b1, 2'b01, rnd(), rnd(), 2'd2, "tp4_stall");
        check("tp4_count4", EW'(count), EW'(4));
        step(1'b0, 1'b0, 2'b00, '0, '0, 2'd2, "tp4_release");

        // 5: steady 2-in/2-out across pointer wrap
        pulse_reset("rst5");
        step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd0, "wrap_prime");
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd2, "wrap");
            check("wrap_count2", EW'(count), EW'(2));
        end

        // 6: flush beats stall and enqueue; then async reset mid-stream
        pulse_reset("rst6");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd0, "fill10");
        step(1'b1, 1'b1, 2'b11, rnd(), rnd(), 2'd0, "tp6_flush");
        check("tp6_count0", EW'(count), EW'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'd1, "refill");
        pulse_reset("tp6_async");

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            bit fl, st;
            logic [1:0] iv, dn;
            fl = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 3) == 0);
            iv = 2'($urandom);
            dn = 2'($urandom_range(0, 3));
            if ((i / 50) % 2 == 0 && dn > 1) dn = 2'd0;
            if ($urandom_range(0, 149) == 0) pulse_reset("rnd_rst");
            step(fl, st, iv, rnd(), rnd(), dn, "rnd");
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue_mw.md
Name: issue_queue_mw

Overview:
- Parametrised multi-lane FIFO issue buffer between decode and issue logic. Generalises the fixed 16-entry, 2-in/2-out decoded-instruction buffer.
- Adds configurable depth, entry width and lane counts, compaction of sparse input lanes, and an exact occupancy count.
- Adds stall-preserving first-word-fall-through outputs, overflow protection with a sticky error flag, and a programmable almost-full threshold.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
ENTRY_W, 256, bit width of one decoded-instruction entry
IN_W, 2, enqueue lanes per cycle, 1..4
OUT_W, 2, dequeue lanes per cycle, 1..4
AFULL_SLACK, 4, almost_full asserts when free entries < AFULL_SLACK

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  discard all contents (branch mispredict)
stall  in  1  downstream stall; blocks dequeue only
in_valid  in  IN_W  per-lane enqueue valid; lanes may be sparse
in_data  in  IN_W*ENTRY_W  lane i occupies bits [i*ENTRY_W +: ENTRY_W]
deq_num  in  $clog2(OUT_W+1)  number of head entries consumed this cycle
out_valid  out  OUT_W  thermometer valid of head entries (bit0 = oldest)
out_data  out  OUT_W*ENTRY_W  head entries, lane 0 = oldest
count  out  $clog2(DEPTH+1)  current occupancy
almost_full  out  1  registered, (DEPTH - count) < AFULL_SLACK
overflow_err  out  1  sticky; set when a valid input lane is dropped

Behaviour:
- Reset (rstn low, async): head = tail = 0, count = 0, out_valid = 0, almost_full = 0, overflow_err = 0. Storage contents are don't-care and never exposed while out_valid = 0. Reset mid-operation discards everything, including pending enqueues.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are resolved by count, never by pointer equality.
- Outputs are combinational from state (first-word fall-through):
  - out_valid[k] = (count > k).
  - out_data lane k = mem[(tail + k) mod DEPTH]. Lanes with out_valid = 0 are don't-care.
- Dequeue:
  - eff_deq = stall ? 0 : min(deq_num, count, OUT_W).
  - tail += eff_deq.
  - deq_num above available entries is clamped silently.
- stall holds tail and out_valid/out_data unchanged. Enqueue continues during stall.
- Enqueue:
  - Valid lanes are compacted in ascending lane order. The n-th set bit of in_valid is written to (head + n) mod DEPTH.
  - n_in = popcount(in_valid).
  - space = DEPTH - count + eff_deq. Same-cycle dequeue frees space.
  - Accepted = min(n_in, space); head += accepted.
  - Excess lanes (highest lane indices first) are dropped, and overflow_err sets. overflow_err is cleared only by reset.
- count_next = count + accepted - eff_deq.
- almost_full registers (DEPTH - count_next) < AFULL_SLACK.
- flush (priority over stall and enqueue):
  - Next cycle head = tail = 0, count = 0, out_valid = 0, almost_full = 0.
  - Same-cycle enqueue is discarded.
  - overflow_err is unaffected.
- Single-cycle latency: an entry enqueued in cycle t is visible on out_valid/out_data in cycle t+1.
- DEPTH = 16, IN_W = OUT_W = 2 must be drop-in compatible with the current 2-wide issue path.

Test Plan:
1. Reset, then in_valid = 2'b11 with A, B; deq_num = 0 -> next cycle count = 2, out_valid = 2'b11, out_data = {B, A}; almost_full = 0.
2. in_valid = 2'b10 (lane1 = C only) into empty queue -> C lands in lane 0 of the outputs; count = 1, out_valid = 2'b01.
3. Fill to 15 entries, then present 2 valid lanes with deq_num = 0 -> one lane accepted, count = 16, overflow_err = 1, almost_full = 1. Repeat with deq_num = 1 after reset -> both accepted, count = 16, overflow_err = 0.
4. count = 3, stall = 1, deq_num = 2, enqueue 1 -> count = 4, out_data unchanged, tail unchanged. Release stall with deq_num = 2 -> count = 2.
5. Wrap-around: cycle 30 entries through 2-in/2-out steady state -> output order identical to input order across pointer wrap, count constant at 2.
6. count = 10 with flush = 1, stall = 1 and in_valid = 2'b11 -> next cycle count = 0, out_valid = 0, almost_full = 0. Async rstn pulse mid-stream -> all outputs 0 immediately.
